// File: rtl/aes_pkg.sv
// Shared AES types, FSM encodings, Rcon table and GF(2^8) byte-level helpers.
// The S-box is computed algebraically as GF inverse followed by the affine map.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_KEYEXP = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic int nr_of(input int keyBits);
        return (keyBits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // inv = x^254 = x^2 * x^4 * ... * x^128; zero maps to zero as required
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gmul(x, x);
        inv = sq;
        for (int k = 2; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t subWord(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic block_t subBytes(input block_t s);
        block_t o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte n of the block is state[row n%4][col n/4], column-major as in FIPS-197
    function automatic block_t shiftRows(input block_t s);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic block_t mixColumns(input block_t s);
        block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One key-expansion step: produces the next four schedule words from an
// 8-word window (window[255:128] = older round key, window[127:0] = newest).
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic [255:0] window,
    input  logic [3:0]   stepIdx,
    output logic [127:0] nextKey
);

    word_t      lastWord;
    word_t      rotated;
    word_t      temp;
    word_t      w0, w1, w2, w3;
    block_t     base;
    logic       doRot;
    logic [3:0] rconIdx;
    logic [7:0] rconByte;

    assign lastWord = window[31:0];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        doRot   = 1'b1;
        rconIdx = stepIdx - 4'd1;
        base    = window[127:0];
        if (KEY_BITS == 256) begin
            // Odd steps start a new 8-word group (Rot+Sub+Rcon); even steps are Sub only
            doRot   = stepIdx[0];
            rconIdx = (stepIdx - 4'd1) >> 1;
            base    = window[255:128];
        end
        rconByte = (rconIdx > 4'd9) ? RCON[0] : RCON[rconIdx];
        rotated  = doRot ? {lastWord[23:0], lastWord[31:24]} : lastWord;
        temp     = subWord(rotated) ^ (doRot ? {rconByte, 24'h0} : 32'h0);
        w0       = base[127:96] ^ temp;
        w1       = base[95:64]  ^ w0;
        w2       = base[63:32]  ^ w1;
        w3       = base[31:0]   ^ w2;
        nextKey  = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_cipher_param.sv
// AES-128/256 encryption engine, one round per clock, cached key schedule.
// Define AES_CBC_EN to add the iv port and CBC chaining; default build is ECB.
module aes_cipher_param
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] key,
    input  logic                key_valid,
    output logic                key_ready,
    output logic                key_loaded,
`ifdef AES_CBC_EN
    input  logic [127:0]        iv,
`endif
    input  logic [127:0]        in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [127:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int NR        = nr_of(KEY_BITS);
    localparam int KEY_STEPS = (KEY_BITS == 256) ? 13 : 10;
    localparam int RK_BASE   = (KEY_BITS == 256) ? 1 : 0;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : gBadKeyBits
        $error("aes_cipher_param: KEY_BITS must be 128 or 256");
    end

    logic [1:0]   fsmState;
    logic [3:0]   stepIdx;
    logic [3:0]   roundIdx;
    logic [3:0]   rkWrIdx;
    logic [255:0] keyWindow;
    logic [255:0] initWindow;
    logic [127:0] nextKey;
    block_t       rk [0:NR];
    block_t       rkSel;
    block_t       dataReg;
    block_t       srOut;
    block_t       roundOut;
    block_t       chainReg;
    logic         keyFire;
    logic         inFire;

    assign key_ready = (fsmState == ST_IDLE);
    assign in_ready  = (fsmState == ST_IDLE) & key_loaded & ~key_valid;
    assign busy      = (fsmState == ST_KEYEXP) | (fsmState == ST_ROUND);
    assign keyFire   = key_valid & key_ready;
    assign inFire    = in_valid & in_ready;
    assign rkWrIdx   = stepIdx + 4'(RK_BASE);

    aes_key_step #(.KEY_BITS(KEY_BITS)) uKeyStep (
        .window  (keyWindow),
        .stepIdx (stepIdx),
        .nextKey (nextKey)
    );

    always_comb begin
        initWindow                 = '0;
        initWindow[KEY_BITS-1:0]   = key;
        rkSel                      = '0;
        for (int i = 0; i <= NR; i++)
            if (roundIdx == 4'(i)) rkSel = rk[i];
    end

    // The last round skips MixColumns
    assign srOut    = shiftRows(subBytes(dataReg));
    assign roundOut = ((roundIdx == 4'(NR)) ? srOut : mixColumns(srOut)) ^ rkSel;

    // NOTE: the round-key table has no reset; key_loaded=0 already marks it invalid.
    always_ff @(posedge clk) begin
        if (keyFire) begin
            rk[0] <= key[KEY_BITS-1 -: 128];
            if (KEY_BITS == 256) rk[1] <= key[127:0];
        end else if (fsmState == ST_KEYEXP) begin
            for (int i = 1; i <= NR; i++)
                if (rkWrIdx == 4'(i)) rk[i] <= nextKey;
        end
    end

`ifdef AES_CBC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       chainReg <= '0;
        else if (keyFire)                                 chainReg <= iv;
        else if (fsmState == ST_HOLD && out_ready)        chainReg <= out_data;
    end
`else
    assign chainReg = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsmState   <= ST_IDLE;
            key_loaded <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            stepIdx    <= '0;
            roundIdx   <= '0;
            dataReg    <= '0;
            keyWindow  <= '0;
        end else begin
            case (fsmState)
                ST_IDLE: begin
                    if (keyFire) begin
                        key_loaded <= 1'b0;
                        keyWindow  <= initWindow;
                        stepIdx    <= 4'd1;
                        fsmState   <= ST_KEYEXP;
                    end else if (inFire) begin
                        dataReg  <= in_data ^ chainReg ^ rk[0];
                        roundIdx <= 4'd1;
                        fsmState <= ST_ROUND;
                    end
                end
                ST_KEYEXP: begin
                    keyWindow <= {keyWindow[127:0], nextKey};
                    if (stepIdx == 4'(KEY_STEPS)) begin
                        stepIdx    <= '0;
                        key_loaded <= 1'b1;
                        fsmState   <= ST_IDLE;
                    end else begin
                        stepIdx <= stepIdx + 4'd1;
                    end
                end
                ST_ROUND: begin
                    if (roundIdx == 4'(NR)) begin
                        out_data  <= roundOut;
                        out_valid <= 1'b1;
                        roundIdx  <= '0;
                        fsmState  <= ST_HOLD;
                    end else begin
                        dataReg  <= roundOut;
                        roundIdx <= roundIdx + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsmState  <= ST_IDLE;
                    end
                end
                default: fsmState <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_param.sv
// Directed FIPS-197 / SP800-38A vectors against an AES-128 and an AES-256 instance.
// Build with AES_CBC_EN defined to exercise the CBC chaining path.
module tb_aes_cipher_param;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [127:0] key, inData, outData;
    logic         keyValid, keyReady, keyLoaded, inValid, inReady, outValid, outReady, busy;
    logic [255:0] key2;
    logic [127:0] in2Data, out2Data;
    logic         key2Valid, key2Ready, key2Loaded, in2Valid, in2Ready, out2Valid, out2Ready, busy2;
`ifdef AES_CBC_EN
    logic [127:0] iv, iv2;
`endif

    int errCount   = 0;
    int checkCount = 0;

    aes_cipher_param #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .key(key), .key_valid(keyValid), .key_ready(keyReady),
        .key_loaded(keyLoaded),
`ifdef AES_CBC_EN
        .iv(iv),
`endif
        .in_data(inData), .in_valid(inValid), .in_ready(inReady), .out_data(outData),
        .out_valid(outValid), .out_ready(outReady), .busy(busy)
    );

    aes_cipher_param #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .key(key2), .key_valid(key2Valid), .key_ready(key2Ready),
        .key_loaded(key2Loaded),
`ifdef AES_CBC_EN
        .iv(iv2),
`endif
        .in_data(in2Data), .in_valid(in2Valid), .in_ready(in2Ready), .out_data(out2Data),
        .out_valid(out2Valid), .out_ready(out2Ready), .busy(busy2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey(input logic [127:0] k, input string tag);
        int n;
        key      = k;
        keyValid = 1'b1;
        n = 0;
        while (!keyReady && n < 50) begin tick(); n++; end
        tick();
        keyValid = 1'b0;
        check({tag, " busy in KEYEXP"}, 128'(busy), 128'd1);
        n = 0;
        while (!keyLoaded && n < 50) begin tick(); n++; end
        check({tag, " keyexp cycles"}, 128'(n), 128'd10);
    endtask

    task automatic runBlock(input logic [127:0] pt, input logic [127:0] ct, input int stall,
                            input string tag);
        int n;
        n = 0;
        while (!inReady && n < 50) begin tick(); n++; end
        check({tag, " in_ready"}, 128'(inReady), 128'd1);
        inData  = pt;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 50) begin tick(); n++; end
        check({tag, " latency"}, 128'(n), 128'd10);
        check({tag, " ciphertext"}, outData, ct);
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, " stalled out_data"}, outData, ct);
            check({tag, " stalled out_valid"}, 128'(outValid), 128'd1);
            check({tag, " stalled in_ready"}, 128'(inReady), 128'd0);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        check({tag, " out_valid drop"}, 128'(outValid), 128'd0);
        check({tag, " out_data kept"}, outData, ct);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  n;
        logic sawValid, sawReady;
        rst_n = 1'b0;
        key = '0; keyValid = 0; inData = '0; inValid = 0; outReady = 0;
        key2 = '0; key2Valid = 0; in2Data = '0; in2Valid = 0; out2Ready = 0;
`ifdef AES_CBC_EN
        iv = '0; iv2 = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset key_loaded", 128'(keyLoaded), 128'd0);
        check("reset out_valid", 128'(outValid), 128'd0);
        check("reset out_data", outData, 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset in_ready", 128'(inReady), 128'd0);
        check("reset key_ready", 128'(keyReady), 128'd1);
        rst_n = 1'b1;
        tick();

`ifdef AES_CBC_EN
        iv = KEY_C1;
        loadKey(KEY_B, "cbc key");
        runBlock(128'h6bc1bee22e409f96e93d7e117393172a, 128'h7649abac8119b246cee98e9b12e9197d, 0, "cbc blk1");
        runBlock(128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h5086cb9b507219ee95db113a917678b2, 0, "cbc blk2");
        iv = '0;
`else
        loadKey(KEY_C1, "reuse key");
        runBlock(PT_C, CT_C1, 0, "reuse blk1");
        runBlock(PT_C, CT_C1, 5, "reuse blk2");
        runBlock(PT_C, CT_C1, 0, "reuse blk3");
`endif

        // Key and plaintext offered together while a key is loaded
        key = KEY_B; keyValid = 1'b1; inData = PT_B; inValid = 1'b1;
        #1;
        check("prio in_ready masked", 128'(inReady), 128'd0);
        check("prio key_ready", 128'(keyReady), 128'd1);
        tick();
        keyValid = 1'b0;
        n = 0;
        while (!keyLoaded && n < 50) begin
            check("prio in_ready in KEYEXP", 128'(inReady), 128'd0);
            tick();
            n++;
        end
        check("prio keyexp cycles", 128'(n), 128'd10);
        runBlock(PT_B, CT_B, 0, "appB");

        // Reset while round 5 is pending
        inData = PT_B; inValid = 1'b1;
        tick();
        inValid = 1'b0;
        repeat (4) tick();
        check("pre-reset busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check("midreset key_loaded", 128'(keyLoaded), 128'd0);
        check("midreset busy", 128'(busy), 128'd0);
        check("midreset out_valid", 128'(outValid), 128'd0);
        tick();
        rst_n = 1'b1;
        inValid = 1'b1;
        sawValid = 1'b0; sawReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawValid |= outValid;
            sawReady |= inReady;
        end
        inValid = 1'b0;
        check("post-reset out_valid never", 128'(sawValid), 128'd0);
        check("post-reset in_ready never", 128'(sawReady), 128'd0);
        loadKey(KEY_C1, "reload key");
        runBlock(PT_C, CT_C1, 0, "reload blk");

        // AES-256 instance
        key2 = KEY_C3; key2Valid = 1'b1;
        tick();
        key2Valid = 1'b0;
        n = 0;
        while (!key2Loaded && n < 50) begin tick(); n++; end
        check("aes256 keyexp cycles", 128'(n), 128'd13);
        in2Data = PT_C; in2Valid = 1'b1;
        #1;
        check("aes256 in_ready", 128'(in2Ready), 128'd1);
        tick();
        in2Valid = 1'b0;
        n = 0;
        while (!out2Valid && n < 50) begin tick(); n++; end
        check("aes256 latency", 128'(n), 128'd14);
        check("aes256 ciphertext", out2Data, CT_C3);
        check("aes256 busy in HOLD", 128'(busy2), 128'd0);
        out2Ready = 1'b1;
        tick();
        out2Ready = 1'b0;
        check("aes256 out_valid drop", 128'(out2Valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
